seq_divider: RTL and testbench
==============================

// Module: seq_divider
// PURPOSE
//  Iterative signed integer divider, the inverse companion of the combinational multiplier.
//  Computes quotient and remainder of two N-bit two's-complement operands.
//  Uses restoring division, one quotient bit per clock, with a start/done handshake.
//  Sits beside the multiplier in the arithmetic unit and shares its operand width parameter.
// PARAMETERS
//  N  32  operand width in bits (dividend, divisor, quotient and remainder); N >= 4
// PORTS
//  clk           input   1  single clock; all state updates on the rising edge
//  rst           input   1  asynchronous, active-high reset
//  start         input   1  request; sampled only while busy=0
//  A             input   N  signed dividend; captured on the accepting edge
//  B             input   N  signed divisor; captured on the accepting edge
//  busy          output  1  high from the accepting edge until done is raised
//  done          output  1  one-cycle pulse; results are valid from this cycle
//  Q             output  N  signed quotient
//  R             output  N  signed remainder
//  div_by_zero   output  1  high with done when captured B == 0; held like Q and R
// BEHAVIOUR
//  Reset: state=IDLE; busy=0, done=0, Q=0, R=0, div_by_zero=0.
//    Reset asserted mid-operation aborts the operation. No done is produced.
//  FSM states: IDLE -> CALC -> FIX -> IDLE.
//    IDLE: when start=1, capture |A|, |B|, sign(A) and sign(A)^sign(B).
//      Set busy=1, load the iteration counter to N-1, clear the partial remainder, go to CALC.
//    CALC: shift {rem, dvd} left by 1 and trial-subtract |B|.
//      If the result is non-negative, keep it and set q bit=1; otherwise restore and set q bit=0.
//      Decrement the counter. Leave for FIX after exactly N CALC cycles.
//    FIX: apply signs.
//      Q = qsign ? -q : q.
//      R = asign ? -rem : rem.
//      Register Q, R and div_by_zero; set done=1 and busy=0; go to IDLE.
//  Latency: done is high N+2 rising edges after the edge that accepted start (34 for N=32).
//    Latency is identical for every operand, including zero and overflow cases.
//  done is high for exactly 1 cycle.
//  Q, R and div_by_zero hold their values until the next FIX. They are not cleared on a new start.
//  start while busy=1 is ignored: it is neither queued nor does it alter the captured operands.
//  start in the cycle done is high: busy=0, so the new start is accepted (back-to-back operation).
//  Rounding: truncation toward zero. R takes the sign of the dividend, and |R| < |B|.
//    Invariant: A == Q*B + R whenever B != 0.
//  Absolute values are computed in N+1 bits, so |MIN| = 2^(N-1) is exact.
//  Overflow, MIN / -1: Q = MIN (wraps), R = 0, div_by_zero = 0.
//  Divide by zero, B == 0: Q = all ones (-1), R = A, div_by_zero = 1.
//    Same latency; the CALC result is overridden in FIX.
//  A and B may change freely after the accepting edge without affecting the result.
// STRUCTURE
//  Shared package file div_pkg.vh:
//    FSM state encodings (S_IDLE, S_CALC, S_FIX, 2 bits).
//    Counter width localparam $clog2(N).
//  Sub-module twos_abs #(N): combinational {sign, N+1-bit magnitude} from an N-bit signed input.
//    Instantiated twice, for A and B.
//    Final negation is done inline in FIX.
//  Datapath registers: rem[N:0], dvd[N-1:0], divisor magnitude [N:0], count, qsign, asign, bzero.
// TESTING
//  Self-checking bench; check results at the done pulse and count busy-to-done cycles against N+2.
//  1. A=50, B=-5 -> Q=-10, R=0, div_by_zero=0, done at edge 34.
//  2. A=-797079, B=1011 -> Q=-788, R=-411; also A=7, B=-2 -> Q=-3, R=1; A=-7, B=-2 -> Q=3, R=-1.
//  3. A=12345, B=0 -> Q=32'hFFFFFFFF, R=12345, div_by_zero=1, done at edge 34.
//  4. A=32'h80000000, B=-1 -> Q=32'h80000000, R=0; A=32'h80000000, B=1 -> Q=32'h80000000, R=0.
//  5. Protocol: start pulse while busy (A=99, B=9) -> ignored; first result (e.g. 45/3 -> 15 r0) unchanged.
//     Start in the done cycle with 42/-6 -> accepted, Q=-7.
//  6. Reset asserted at edge 10 of an operation -> busy, done, Q, R and div_by_zero all 0 immediately.
//     No done is produced; the next start completes normally.

Source files
------------

// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider: FSM encodings and sizing helpers.
package div_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    localparam int N_DEFAULT = 32;

    // Iteration counter width; holds N-1 down to 0.
    function automatic int cnt_width(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/seq_divider_twos_abs.sv
// Combinational sign and magnitude of an N-bit two's-complement value.
// The magnitude is one bit wider so that |MIN| is exact.
module twos_abs #(
    parameter int N = 32
) (
    input  logic [N-1:0] a_i,
    output logic         sign_o,
    output logic [N:0]   mag_o
);

    logic [N:0] ext;

    assign ext    = {a_i[N-1], a_i};
    assign sign_o = a_i[N-1];
    assign mag_o  = sign_o ? -ext : ext;

endmodule

// File: rtl/seq_divider.sv
// Iterative signed restoring divider: one quotient bit per clock, start/done handshake,
// truncating toward zero with the remainder taking the dividend's sign.
module seq_divider
    import div_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] Q,
    output logic [N-1:0] R,
    output logic         div_by_zero
);

    localparam int CNT_W = cnt_width(N);

    state_t             state_q, state_d;
    logic [N:0]         rem_q, rem_d;
    logic [N-1:0]       dvd_q, dvd_d;
    logic [N:0]         dsr_q, dsr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               qsign_q, qsign_d;
    logic               asign_q, asign_d;
    logic               bzero_q, bzero_d;
    logic [N-1:0]       q_q, q_d;
    logic [N-1:0]       r_q, r_d;
    logic               dbz_q, dbz_d;
    logic               done_q, done_d;

    logic               load_en, calc_en, fix_en;
    logic               sign_a, sign_b;
    logic [N:0]         mag_a, mag_b;
    logic               unused_mag_a_msb;
    logic [N+1:0]       shifted, diff;
    logic               diff_neg;

    twos_abs #(.N(N)) u_abs_a (.a_i(A), .sign_o(sign_a), .mag_o(mag_a));
    twos_abs #(.N(N)) u_abs_b (.a_i(B), .sign_o(sign_b), .mag_o(mag_b));

    // |A| never exceeds 2^(N-1), so it fits the N-bit dividend register.
    assign unused_mag_a_msb = mag_a[N];

    assign shifted  = {rem_q, dvd_q[N-1]};
    assign diff     = shifted - {1'b0, dsr_q};
    assign diff_neg = diff[N+1];

    // NOTE: async reset clears every register, including results, so an aborted op leaves no stale Q/R.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            // NOTE: non-blocking assignments keep all registers sampling pre-edge values.
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: defaulting every comb output first is what prevents latch inference.
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start) state_d = S_CALC;
            S_CALC:  if (cnt_q == '0) state_d = S_FIX;
            S_FIX:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy    = (state_q != S_IDLE);
        load_en = (state_q == S_IDLE) && start;
        calc_en = (state_q == S_CALC);
        fix_en  = (state_q == S_FIX);
    end

    always_comb begin
        rem_d   = rem_q;
        dvd_d   = dvd_q;
        dsr_d   = dsr_q;
        cnt_d   = cnt_q;
        qsign_d = qsign_q;
        asign_d = asign_q;
        bzero_d = bzero_q;
        q_d     = q_q;
        r_d     = r_q;
        dbz_d   = dbz_q;
        done_d  = 1'b0;
        if (load_en) begin
            rem_d   = '0;
            dvd_d   = mag_a[N-1:0];
            dsr_d   = mag_b;
            cnt_d   = CNT_W'(N - 1);
            qsign_d = sign_a ^ sign_b;
            asign_d = sign_a;
            bzero_d = (mag_b == '0);
        end
        if (calc_en) begin
            rem_d = diff_neg ? shifted[N:0] : diff[N:0];
            dvd_d = {dvd_q[N-2:0], ~diff_neg};
            cnt_d = cnt_q - CNT_W'(1);
        end
        if (fix_en) begin
            // With a zero divisor the remainder path already yields A; only Q needs forcing.
            q_d    = bzero_q ? '1 : (qsign_q ? -dvd_q : dvd_q);
            r_d    = asign_q ? -rem_q[N-1:0] : rem_q[N-1:0];
            dbz_d  = bzero_q;
            done_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q   <= '0;
            dvd_q   <= '0;
            dsr_q   <= '0;
            cnt_q   <= '0;
            qsign_q <= 1'b0;
            asign_q <= 1'b0;
            bzero_q <= 1'b0;
            q_q     <= '0;
            r_q     <= '0;
            dbz_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            dsr_q   <= dsr_d;
            cnt_q   <= cnt_d;
            qsign_q <= qsign_d;
            asign_q <= asign_d;
            bzero_q <= bzero_d;
            q_q     <= q_d;
            r_q     <= r_d;
            dbz_q   <= dbz_d;
            done_q  <= done_d;
        end
    end

    assign done        = done_q;
    assign Q           = q_q;
    assign R           = r_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider (N=32). Edges are counted with the accepting edge as edge 1,
// so done must first be seen after edge 34.
module tb_seq_divider;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] a, b;
    logic        busy, done, dbz;
    logic [31:0] q, r;

    int n_cmp = 0;
    int n_err = 0;
    int edges = 0;

    seq_divider #(.N(32)) dut (
        .clk(clk), .rst(rst), .start(start), .A(a), .B(b),
        .busy(busy), .done(done), .Q(q), .R(r), .div_by_zero(dbz)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        edges++;
    endtask

    task automatic launch(input logic [31:0] av, input logic [31:0] bv);
        start = 1'b1;
        a     = av;
        b     = bv;
        edges = 0;
        tick();
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
    endtask

    task automatic wait_done(input string tag);
        while (!done && edges < 60) tick();
        check({tag, " done"}, 32'(done), 32'd1);
        check({tag, " latency"}, 32'(edges), 32'd34);
        check({tag, " busy@done"}, 32'(busy), 32'd0);
    endtask

    task automatic op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                      input logic [31:0] eq, input logic [31:0] er, input logic edbz);
        launch(av, bv);
        check({tag, " busy"}, 32'(busy), 32'd1);
        wait_done(tag);
        check({tag, " Q"}, q, eq);
        check({tag, " R"}, r, er);
        check({tag, " dbz"}, 32'(dbz), 32'(edbz));
    endtask

    initial begin
        int done_seen;
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        #12;
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst Q", q, 32'd0);
        check("rst R", r, 32'd0);
        check("rst dbz", 32'(dbz), 32'd0);
        rst = 1'b0;
        #1;

        op("50/-5", 32'd50, -32'sd5, -32'sd10, 32'd0, 1'b0);
        tick();
        check("done one cycle", 32'(done), 32'd0);
        op("-797079/1011", -32'sd797079, 32'd1011, -32'sd788, -32'sd411, 1'b0);
        op("7/-2", 32'd7, -32'sd2, -32'sd3, 32'd1, 1'b0);
        op("-7/-2", -32'sd7, -32'sd2, 32'd3, -32'sd1, 1'b0);
        op("12345/0", 32'd12345, 32'd0, 32'hFFFF_FFFF, 32'd12345, 1'b1);
        op("-50/0", -32'sd50, 32'd0, 32'hFFFF_FFFF, -32'sd50, 1'b1);
        op("MIN/-1", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0);
        op("MIN/1", 32'h8000_0000, 32'd1, 32'h8000_0000, 32'd0, 1'b0);

        // Start while busy must be ignored; start in the done cycle must be accepted.
        launch(32'd45, 32'd3);
        repeat (4) tick();
        start = 1'b1;
        a     = 32'd99;
        b     = 32'd9;
        tick();
        start = 1'b0;
        wait_done("45/3");
        check("45/3 Q", q, 32'd15);
        check("45/3 R", r, 32'd0);
        op("b2b 42/-6", 32'd42, -32'sd6, -32'sd7, 32'd0, 1'b0);

        // Abort mid-operation with reset.
        launch(32'd1000, 32'd7);
        while (edges < 10) tick();
        rst = 1'b1;
        #1;
        check("abort busy", 32'(busy), 32'd0);
        check("abort done", 32'(done), 32'd0);
        check("abort Q", q, 32'd0);
        check("abort R", r, 32'd0);
        check("abort dbz", 32'(dbz), 32'd0);
        tick();
        rst = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done) done_seen++;
        end
        check("abort no done", 32'(done_seen), 32'd0);
        op("after abort 100/7", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
